// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard that stalls ID on pending sources and gates branch flushes
// Ports: Clk, Reset (async, active-high); ID_* describe the instruction in ID; Branch_Taken, ID_Flush
// are control inputs; ID_Stall and Flush_IF_ID are combinational; Pending and Stall_Count are registered.
module hazard_scoreboard #(
    parameter int ADDR_W    = 5,
    parameter int LAT_W     = 2,
    parameter int FWD_EN    = 1,
    parameter int LOAD_LAT  = 1,
    parameter int NOFWD_LAT = 2,
    parameter int CNT_W     = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  ID_Valid,
    input  logic [ADDR_W-1:0]     ID_Rs,
    input  logic [ADDR_W-1:0]     ID_Rt,
    input  logic                  ID_UsesRs,
    input  logic                  ID_UsesRt,
    input  logic                  ID_RegWrite,
    input  logic [ADDR_W-1:0]     ID_Dst,
    input  logic                  ID_MemRead,
    input  logic                  Branch_Taken,
    input  logic                  ID_Flush,
    output logic                  ID_Stall,
    output logic                  Flush_IF_ID,
    output logic [2**ADDR_W-1:0]  Pending,
    output logic [CNT_W-1:0]      Stall_Count
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [LAT_W-1:0] LOAD_L  = LAT_W'(LOAD_LAT);
    localparam logic [LAT_W-1:0] NOFWD_L = LAT_W'(NOFWD_LAT);
    if (LOAD_LAT < 0 || NOFWD_LAT < 0 || LOAD_LAT >= 2**LAT_W || NOFWD_LAT >= 2**LAT_W) begin : g_bad_lat
        $fatal(1, "hazard_scoreboard: LOAD_LAT/NOFWD_LAT do not fit in LAT_W bits");
    end
    logic             hazard;
    logic             issue;
    logic [LAT_W-1:0] ld;
    always_comb begin
        hazard      = ID_Valid & ((ID_UsesRs & Pending[ID_Rs]) | (ID_UsesRt & Pending[ID_Rt]));
        ID_Stall    = hazard & ~ID_Flush;
        Flush_IF_ID = Branch_Taken & ~ID_Stall;
        issue       = ID_Valid & ~ID_Stall & ~ID_Flush & ID_RegWrite & (ID_Dst != '0);
        // with forwarding only loads owe a stall; L = 0 means no entry is created
        ld          = (FWD_EN != 0) ? (ID_MemRead ? LOAD_L : '0) : NOFWD_L;
    end
    assign Pending[0] = 1'b0;
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic [LAT_W-1:0] cnt;
        logic [LAT_W-1:0] dec;
        logic             load;
        always_comb begin
            dec  = (cnt != '0) ? cnt - 1'b1 : '0;
            load = issue & (ID_Dst == ADDR_W'(r)) & (ld != '0);
        end
        // a re-issued writer never shortens an outstanding countdown
        always_ff @(posedge Clk or posedge Reset)
            if (Reset)
                cnt <= '0;
            else
                cnt <= load ? ((dec > ld) ? dec : ld) : dec;
        assign Pending[r] = cnt != '0;
    end
    always_ff @(posedge Clk or posedge Reset)
        if (Reset)
            Stall_Count <= '0;
        else if (ID_Stall && Stall_Count != '1)
            Stall_Count <= Stall_Count + 1'b1;
endmodule
